relm_spi_master: RTL

Hardware SPI byte engine placed between a CPU push/pop port pair and the USB host-controller SPI pins (ss, sck, mosi, miso, int). It replaces per-bit software toggling of sck/mosi: the CPU pushes one command word per byte, and the block shifts 8 bits MSB-first in SPI mode 3 (CPOL=1, CPHA=1). The received byte, a synchronised int level and a busy flag are returned on the pop side.

---
 rtl/relm_spi_master.sv | 116 +++++++++++
 1 files changed

// File: rtl/relm_spi_master.sv
// relm_spi_master: CPU push/pop driven SPI mode-3 byte engine, MSB first, with rx status and int sync.
module relm_spi_master #(
  parameter int WD  = 32,
  parameter int DIV = 4
) (
  input  logic          clk,
  input  logic          reset_in,
  input  logic [WD:0]   push_d,
  output logic          push_retry,
  input  logic          pop_re,
  output logic [WD:0]   pop_q,
  output logic          spi_ss_out,
  output logic          spi_sck_out,
  output logic          spi_mosi_out,
  input  logic          spi_miso_in,
  input  logic          spi_int_in
);
  localparam int CW = $clog2(DIV);
  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;
  state_t          r_st;
  logic [CW-1:0]   r_ph;
  logic [2:0]      r_bit;
  logic [7:0]      r_sh;
  logic [7:0]      r_rx;
  logic            r_rxv;
  logic            r_ovf;
  logic            r_busy;
  logic            r_ss;
  logic            r_sck;
  logic            r_mosi;
  logic [1:0]      r_int;
  logic            w_last;
  logic            w_done;
  logic [7:0]      w_nsh;
  logic            w_unused;
  assign w_last = r_ph == CW'(DIV - 1);
  assign w_done = r_st == HIGH && w_last && r_bit == 3'd0;
  assign w_nsh  = {r_sh[6:0], spi_miso_in};
  assign w_unused = &{1'b0, push_d[WD-1:11]};
  assign push_retry   = r_busy;
  assign spi_ss_out   = r_ss;
  assign spi_sck_out  = r_sck;
  assign spi_mosi_out = r_mosi;
  always_comb begin
    pop_q = '0;
    pop_q[WD-1] = r_rxv;
    pop_q[WD-2] = r_ovf;
    pop_q[16] = r_int[1];
    pop_q[15] = r_busy;
    pop_q[7:0] = r_rx;
  end
  always_ff @(posedge clk) begin
    if (reset_in) begin
      r_st   <= IDLE;
      r_ph   <= '0;
      r_bit  <= '0;
      r_sh   <= '0;
      r_rx   <= '0;
      r_rxv  <= 1'b0;
      r_ovf  <= 1'b0;
      r_busy <= 1'b0;
      r_ss   <= 1'b1;
      r_sck  <= 1'b1;
      r_mosi <= 1'b0;
      r_int  <= '0;
    end else begin
      r_int <= {r_int[0], spi_int_in};
      // a completion wins over a same-cycle read: keep the new byte valid, leave overflow as is
      if (w_done) begin
        r_rx  <= w_nsh;
        r_rxv <= 1'b1;
        r_ovf <= r_ovf | (r_rxv & ~pop_re);
      end else if (pop_re) begin
        r_rxv <= 1'b0;
        r_ovf <= 1'b0;
      end
      case (r_st)
        IDLE: if (push_d[WD]) begin
          if (push_d[10]) r_ss <= push_d[9];
          if (push_d[8]) begin
            r_st   <= LOW;
            r_busy <= 1'b1;
            r_sck  <= 1'b0;
            r_mosi <= push_d[7];
            r_sh   <= push_d[7:0];
            r_ph   <= '0;
            r_bit  <= 3'd7;
          end
        end
        LOW: begin
          r_ph <= w_last ? '0 : r_ph + 1'b1;
          if (w_last) begin
            r_st  <= HIGH;
            r_sck <= 1'b1;
          end
        end
        HIGH: begin
          r_ph <= w_last ? '0 : r_ph + 1'b1;
          if (w_last) begin
            r_sh <= w_nsh;
            if (r_bit == 3'd0) begin
              r_st   <= IDLE;
              r_busy <= 1'b0;
            end else begin
              r_st   <= LOW;
              r_sck  <= 1'b0;
              r_mosi <= w_nsh[7];
              r_bit  <= r_bit - 1'b1;
            end
          end
        end
        default: r_st <= IDLE;
      endcase
    end
  end
endmodule
